// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants.
// Used by the fetch queue and its FIFO.
package mips_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] INST_NOP = 32'h0;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc4;
  } fq_entry_t;

  function automatic logic [XLEN-1:0] word_align(
    input logic [XLEN-1:0] a
  );
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fq_fifo.sv
// Circular buffer of fetched instructions.
// Flush clears pointers and count in one cycle.
module fq_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  fq_entry_t     push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output fq_entry_t     head_o
);

  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  fq_entry_t     mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = inc(tail_q);
      if (pop_i) head_d = inc(head_q);
      unique case ({push_i, pop_i})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: reads are gated by count.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[tail_q] <= push_data_i;
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID.
// One outstanding imem request; redirect flushes.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            d_valid,
  input  logic            d_ready,
  output logic [XLEN-1:0] d_inst,
  output logic [XLEN-1:0] d_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] LIM  = CW'(DEPTH - 1);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] tgt, nxt;
  logic [CW-1:0]   count;
  logic            push, pop;
  fq_entry_t       head;
  fq_entry_t       push_data;

  assign tgt = word_align(redirect_pc);
  assign nxt = addr_q + PC_STEP;
  assign pop = d_valid && d_ready;
  assign push_data = '{inst: imem_rdata, pc4: nxt};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    push       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect) begin
          fetch_pc_d = tgt;
        end else if (count < FULL) begin
          state_d = WAIT;
          addr_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (redirect) begin
          fetch_pc_d = tgt;
          state_d    = imem_ack ? IDLE : DRAIN;
        end else if (imem_ack) begin
          push       = 1'b1;
          fetch_pc_d = nxt;
          // Keep streaming only if the next word still fits.
          if ((count - CW'(pop)) < LIM) begin
            addr_d = nxt;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (redirect) fetch_pc_d = tgt;
        if (imem_ack) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
    end
  end

  fq_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .push_data_i(push_data),
    .pop_i      (pop),
    .flush_i    (redirect),
    .count_o    (count),
    .head_o     (head)
  );

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;
  assign d_valid   = (count != '0);
  assign d_inst    = d_valid ? head.inst : INST_NOP;
  assign d_pc      = d_valid ? head.pc4 : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: variable-latency memory
// model plus an entry scoreboard.
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        d_valid;
  logic        d_ready;
  logic [31:0] d_inst;
  logic [31:0] d_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .DEPTH(DEPTH),
    .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .d_valid    (d_valid),
    .d_ready    (d_ready),
    .d_inst     (d_inst),
    .d_pc       (d_pc)
  );

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  int lat = 1;
  int wcnt;
  assign imem_ack   = imem_req && (wcnt == lat - 1);
  assign imem_rdata = word(imem_addr);

  always @(posedge clk) begin
    if (!rst || !imem_req || imem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  fq_entry_t   sb[$];
  fq_entry_t   e;
  logic [31:0] exp_fetch = RST_PC;
  bit          draining = 0;
  int          ack_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      sb.delete();
      exp_fetch = RST_PC;
      draining = 0;
    end else begin
      if (d_valid && d_ready) begin
        if (sb.size() == 0) begin
          chk("pop_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk("d_inst", d_inst, e.inst);
          chk("d_pc", d_pc, e.pc4);
        end
      end
      if (imem_req && imem_ack) begin
        if (redirect || draining) begin
          draining = 0;
        end else begin
          chk("imem_addr", imem_addr, exp_fetch);
          sb.push_back('{inst: word(exp_fetch),
                         pc4: exp_fetch + 32'd4});
          exp_fetch = exp_fetch + 32'd4;
          ack_cnt++;
        end
      end
      if (redirect) begin
        sb.delete();
        exp_fetch = {redirect_pc[31:2], 2'b00};
        if (imem_req && !imem_ack) draining = 1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, RST_PC);
    chk({tag, "_valid"}, 32'(d_valid), 32'd0);
    chk({tag, "_inst"}, d_inst, 32'h0);
    chk({tag, "_pc"}, d_pc, 32'h0);
  endtask

  task automatic restart(input logic rdy, input int l);
    rst = 1'b0;
    redirect = 1'b0;
    d_ready = rdy;
    lat = l;
    tick(1);
    ack_cnt = 0;
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int bound,
                            output int n);
    bit ok = 0;
    n = 0;
    for (int i = 0; i < bound; i++) begin
      if (d_valid) begin
        ok = 1;
        break;
      end
      tick(1);
      n++;
    end
    chk({tag, "_tmo"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int n;
    bit ok;
    rst = 1'b0;
    redirect = 1'b0;
    redirect_pc = '0;
    d_ready = 1'b1;
    tick(2);
    chk_reset_outs("rst");

    // Streaming with single-cycle ack
    rst = 1'b1;
    tick(1);
    chk("s_req1", 32'(imem_req), 32'd1);
    chk("s_addr1", imem_addr, 32'h0);
    chk("s_valid1", 32'(d_valid), 32'd0);
    tick(1);
    for (int i = 0; i < 8; i++) begin
      chk("s_valid", 32'(d_valid), 32'd1);
      chk("s_addr", imem_addr, 32'(4 * (i + 1)));
      tick(1);
    end

    // Backpressure fills the queue
    restart(1'b0, 1);
    tick(12);
    chk("f_req", 32'(imem_req), 32'd0);
    chk("f_acks", 32'(ack_cnt), 32'd4);
    chk("f_sb", 32'(sb.size()), 32'd4);
    chk("f_valid", 32'(d_valid), 32'd1);
    d_ready = 1'b1;
    tick(1);
    d_ready = 1'b0;
    ok = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    chk("f_resume_tmo", 32'(ok), 32'd1);
    chk("f_resume_addr", imem_addr, 32'd16);
    tick(3);
    chk("f_acks2", 32'(ack_cnt), 32'd5);
    chk("f_req2", 32'(imem_req), 32'd0);
    d_ready = 1'b1;
    tick(8);

    // Redirect during a 3-cycle request to 8
    restart(1'b1, 3);
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (imem_req && imem_addr == 32'h8 && wcnt == 1) begin
        ok = 1;
        break;
      end
    end
    chk("r_find_tmo", 32'(ok), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h43;
    tick(1);
    redirect = 1'b0;
    chk("r_valid0", 32'(d_valid), 32'd0);
    chk("r_drain_req", 32'(imem_req), 32'd1);
    chk("r_drain_addr", imem_addr, 32'h8);
    wait_valid("r", 20, n);
    chk("r_lat", 32'(n), 32'd5);
    chk("r_pc", d_pc, 32'h44);
    tick(4);

    // Redirect with ack and pop, count=2
    restart(1'b0, 1);
    ok = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (imem_req && imem_ack && sb.size() == 2) begin
        ok = 1;
        break;
      end
    end
    chk("c_find_tmo", 32'(ok), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    d_ready = 1'b1;
    tick(1);
    redirect = 1'b0;
    chk("c_valid0", 32'(d_valid), 32'd0);
    chk("c_req0", 32'(imem_req), 32'd0);
    tick(1);
    chk("c_valid1", 32'(d_valid), 32'd0);
    chk("c_req1", 32'(imem_req), 32'd1);
    chk("c_addr1", imem_addr, 32'h100);
    tick(1);
    chk("c_valid2", 32'(d_valid), 32'd1);
    chk("c_pc2", d_pc, 32'h104);

    // Reset mid-request with 3 queued
    d_ready = 1'b0;
    lat = 3;
    ok = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (imem_req && sb.size() == 3) begin
        ok = 1;
        break;
      end
    end
    chk("m_find_tmo", 32'(ok), 32'd1);
    rst = 1'b0;
    tick(1);
    chk_reset_outs("m");
    rst = 1'b1;
    d_ready = 1'b1;
    lat = 1;
    tick(1);
    chk("m_req", 32'(imem_req), 32'd1);
    chk("m_addr", imem_addr, RST_PC);
    tick(4);

    // Wrap at the top of the address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick(1);
    redirect = 1'b0;
    wait_valid("w", 10, n);
    chk("w_pc", d_pc, 32'h0);
    chk("w_inst", d_inst, 32'h4FFF_FFFF);
    tick(1);
    chk("w_pc2", d_pc, 32'h4);
    chk("w_inst2", d_inst, 32'h1000_0000);
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue for the pipelined MIPS core, sitting directly upstream of the IF/ID register and decode. It walks the PC, issues word reads to an instruction memory over a variable-latency req/ack handshake, buffers returned instructions with their PC+4 in a small FIFO, and presents them to decode under a valid/ready handshake. A branch redirect from the MEM stage flushes the queue and restarts fetch at the target.

## Interface
- DEPTH, 4: FIFO entries, at least 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- imem_req  out  1  read request, held until acknowledged.
- imem_addr  out  32  word-aligned byte address; stable while imem_req=1.
- imem_ack  in  1  read complete; imem_rdata valid this cycle; ignored when imem_req=0.
- imem_rdata  in  32  instruction word.
- redirect  in  1  taken branch (pc_src from MEM).
- redirect_pc  in  32  branch target; bits [1:0] forced to 0.
- d_valid  out  1  head entry available.
- d_ready  in  1  decode accepts head this cycle.
- d_inst  out  32  head instruction; 0 (nop) when d_valid=0.
- d_pc  out  32  head PC+4; 0 when d_valid=0.

## Operation
- State: fetch_pc (next address to request), count (0..DEPTH), FSM state IDLE / WAIT / DRAIN.
- imem_req = (state != IDLE). imem_addr is a register loaded on entry to WAIT.
- IDLE: if no redirect and count < DEPTH, go WAIT, imem_addr <= fetch_pc. A redirect loads fetch_pc <= redirect_pc and stays in IDLE.
- WAIT, ack, no redirect: push {imem_rdata, imem_addr+4}, fetch_pc <= imem_addr+4. If (count - pop) < DEPTH-1, stay in WAIT with imem_addr <= imem_addr+4, otherwise go IDLE.
- WAIT, redirect (with or without ack): flush, fetch_pc <= redirect_pc, no push. Go IDLE if ack, otherwise DRAIN.
- DRAIN: keep the old imem_addr requested. No push on ack, then go IDLE. A further redirect only updates fetch_pc.
- Pop: when d_valid && d_ready, head advances and count decrements.
- Flush: count <= 0 and the pointers clear. Redirect has priority over push and pop in the same cycle. A pop in the redirect cycle is still taken by decode, and the pipeline squashes it.
- Simultaneous push and pop leaves count unchanged. Overflow is impossible: only one request is outstanding, and it is issued only while count < DEPTH.
- Address arithmetic is 32-bit modulo 2^32. 32'hFFFF_FFFC + 4 wraps to 0 silently.

## Timing
- Reset values, with rst=0 at an edge: state IDLE, fetch_pc=RESET_PC, count=0, imem_req=0, imem_addr=RESET_PC, d_valid=0, d_inst=0, d_pc=0.
- Reset mid-operation discards any outstanding request and all entries. The memory is reset by the same rst.
- Latency: first imem_req in the cycle after rst deasserts. Ack in cycle N gives d_valid in cycle N+1.
- Single-cycle-ack memory with d_ready=1 delivers one instruction per cycle, sustained.
- Redirect in cycle N: d_valid=0 in N+1. With an ack latency of L, the first target instruction is valid no earlier than N+L+2 from WAIT, plus the remaining drain time from DRAIN.
- d_valid, d_inst and d_pc are driven only from registers; no combinational path from imem_rdata.
- d_ready may depend combinationally on d_valid. d_valid must not depend on d_ready.

## Structure
- The shared package mips_pkg holds these constants: XLEN=32, INST_NOP=32'h0, PC_STEP=4.
- mips_pkg also holds the typedef fetch_state_t {IDLE, WAIT, DRAIN} and the struct fq_entry_t {inst, pc4}.
- One sub-module, fq_fifo: a circular buffer of DEPTH entries with push, pop, flush, count, head data and synchronous reset.
- The FSM and the PC logic live in fetch_queue.

## Test plan
- Single-cycle ack, d_ready=1, memory word k = 32'h1000_0000+k: imem_addr 0,4,8,… on consecutive cycles. d_inst 32'h1000_0000,32'h1000_0001,… with d_pc 4,8,12,…, one per cycle from the 3rd cycle after reset.
- d_ready=0, DEPTH=4: exactly 4 pushes, then imem_req=0 with count=4. Raising d_ready for one cycle pops one entry, and fetch resumes at address 16.
- Ack latency 3, redirect to 32'h40 in the 2nd cycle of a request to 8: data for 8 is discarded, the next request is to 32'h40, and the first d_pc after that is 32'h44.
- Redirect coinciding with ack and with a pop while count=2: count=0 next cycle, no push, and the next request goes to redirect_pc.
- rst=0 mid-request with 3 entries queued: next cycle all outputs are at reset values. After release, fetch restarts at RESET_PC.
- Redirect to 32'hFFFF_FFFC: the entry's d_pc=0 and the next fetch address wraps to 0.
